// File: rtl/addsub_pipe_if.sv
// rtl/addsub_pipe_if.sv - operand/result stream bundle for addsub_pipe
`timescale 1ns/1ps
interface addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             control_in;
  logic             sat_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;
  logic             zero_out;
  logic             valid_out;
  logic             ready_in;

  // The adder sits on the slave side: it consumes operands and produces results
  modport slave (
    input  a_in, b_in, control_in, sat_in, valid_in, ready_in,
    output ready_out, sum_out, carry_out, ovf_out, zero_out, valid_out
  );

  modport master (
    output a_in, b_in, control_in, sat_in, valid_in, ready_in,
    input  ready_out, sum_out, carry_out, ovf_out, zero_out, valid_out
  );
endinterface

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - segmented-carry pipelined adder/subtractor with saturation
`timescale 1ns/1ps
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  addsub_pipe_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  generate
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("addsub_pipe: WIDTH must be a non-zero multiple of STAGES");
    end
  endgenerate

  // Per-stage state. a/b carry the full operands (B already conditioned for
  // subtract) so upper segments are available when their stage comes up and
  // the sign bits reach the flag logic; s accumulates finished low segments.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             sat_q [STAGES];
  logic             sat_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             adv;
  logic [WIDTH-1:0] a_i, b_i, s_i;
  logic             c_i, v_i, sat_i, ovf_i;
  logic [SEG:0]     seg_i;
  int               prev;

  // The whole pipe moves together; it only stalls when a finished result is
  // waiting on the downstream side.
  assign adv = ~v_q[STAGES-1] | bus.ready_in;

  // Next-state for every stage: each one adds its own segment using the carry
  // registered by the stage before it; the last stage also forms flags and
  // applies saturation so the output register holds the final result.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    s_d    = s_q;
    sat_d  = sat_q;
    v_d    = v_q;
    c_d    = c_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    a_i    = '0;
    b_i    = '0;
    s_i    = '0;
    c_i    = 1'b0;
    v_i    = 1'b0;
    sat_i  = 1'b0;
    ovf_i  = 1'b0;
    seg_i  = '0;
    prev   = 0;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        prev = (k == 0) ? 0 : k - 1;
        if (k == 0) begin
          a_i   = bus.a_in;
          b_i   = bus.control_in ? ~bus.b_in : bus.b_in;
          s_i   = '0;
          c_i   = bus.control_in;
          v_i   = bus.valid_in;
          sat_i = bus.sat_in;
        end else begin
          a_i   = a_q[prev];
          b_i   = b_q[prev];
          s_i   = s_q[prev];
          c_i   = c_q[prev];
          v_i   = v_q[prev];
          sat_i = sat_q[prev];
        end
        seg_i = {1'b0, a_i[k*SEG +: SEG]} + {1'b0, b_i[k*SEG +: SEG]} + {{SEG{1'b0}}, c_i};
        s_i[k*SEG +: SEG] = seg_i[SEG-1:0];
        if (k == STAGES - 1) begin
          ovf_i = (a_i[MSB] == b_i[MSB]) && (s_i[MSB] != a_i[MSB]);
          ovf_d = ovf_i;
          if (sat_i && ovf_i) begin
            s_i = a_i[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
          zero_d = (s_i == '0);
        end
        a_d[k]   = a_i;
        b_d[k]   = b_i;
        s_d[k]   = s_i;
        c_d[k]   = seg_i[SEG];
        v_d[k]   = v_i;
        sat_d[k] = sat_i;
      end
    end
  end

  // Pipeline registers; reset drops everything in flight and clears the outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        sat_q[k] <= 1'b0;
      end
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      s_q    <= s_d;
      sat_q  <= sat_d;
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.ready_out = adv;
  assign bus.valid_out = v_q[STAGES-1];
  assign bus.sum_out   = s_q[STAGES-1];
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.ovf_out   = ovf_q;
  assign bus.zero_out  = zero_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - randomized and directed bench for addsub_pipe
`timescale 1ns/1ps
module tb_addsub_pipe;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  addsub_pipe_if #(.WIDTH(W)) bus();
  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  always #5 clk = ~clk;

  int   n_err    = 0;
  int   n_checks = 0;
  int   n_out    = 0;
  bit   mon_en   = 1'b0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ctrl, input logic sat);
    res_t m;
    int sa, sb, ua, ub, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r  = ctrl ? sa - sb : sa + sb;
    m.o = (r > 32767) || (r < -32768);
    m.c = ctrl ? (ua >= ub) : (ua + ub > 65535);
    if (sat && r > 32767)       m.sum = 16'h7fff;
    else if (sat && r < -32768) m.sum = 16'h8000;
    else                        m.sum = r[15:0];
    m.z = (m.sum == 16'h0000);
    return m;
  endfunction

  function automatic res_t dut_out();
    return {bus.sum_out, bus.carry_out, bus.ovf_out, bus.zero_out};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7fff;
      1:       return 16'h8000;
      2:       return 16'hffff;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: push the model result on acceptance, compare on consumption,
  // and hold the output steady while stalled
  initial begin : monitor
    res_t prev_out;
    bit   held;
    held = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          exp_q.delete();
          held = 1'b0;
        end else begin
          if (held) begin
            check("hold valid", bus.valid_out, 1);
            check("hold data", dut_out(), prev_out);
          end
          check("ready rule", bus.ready_out, (!bus.valid_out || bus.ready_in));
          if (bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL unexpected output: got %h expected none", dut_out());
            end else begin
              check("result", dut_out(), exp_q.pop_front());
              n_out++;
            end
          end
          if (bus.valid_in && bus.ready_out)
            exp_q.push_back(model(bus.a_in, bus.b_in, bus.control_in, bus.sat_in));
          held = bus.valid_out && !bus.ready_in;
          prev_out = dut_out();
        end
      end
    end
  end

  // Present one operation and hold it until accepted; returns 1ns after the accepting edge
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic ctrl, input logic sat);
    int n;
    bus.a_in = a;
    bus.b_in = b;
    bus.control_in = ctrl;
    bus.sat_in = sat;
    bus.valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready_out && n < 50);
    if (!bus.ready_out) check("accept timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic ctrl, input logic sat, input res_t exp);
    int lat;
    check({name, " model"}, model(a, b, ctrl, sat), exp);
    drive_op(a, b, ctrl, sat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.valid_out && lat < 12);
    check({name, " latency"}, lat, S);
    check({name, " value"}, dut_out(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, " drained"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.control_in = 1'b0;
    bus.sat_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    mon_en = 1'b1;

    // Reset, with valid_in high to show nothing is accepted during reset
    bus.valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("reset outputs", dut_out(), 0);
    check("reset valid_out", bus.valid_out, 0);
    check("reset ready_out", bus.ready_out, 1);
    @(posedge clk);
    #1;

    // Directed cases with hand-computed results
    run_op("add 1234+0f0f", 16'h1234, 16'h0f0f, 1'b0, 1'b0, {16'h2143, 1'b0, 1'b0, 1'b0});
    run_op("sub 5-7",       16'h0005, 16'h0007, 1'b1, 1'b0, {16'hfffe, 1'b0, 1'b0, 1'b0});
    run_op("sub 7-5",       16'h0007, 16'h0005, 1'b1, 1'b0, {16'h0002, 1'b1, 1'b0, 1'b0});
    run_op("add ffff+1",    16'hffff, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
    run_op("add 7fff+1",    16'h7fff, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
    run_op("sat 7fff+1",    16'h7fff, 16'h0001, 1'b0, 1'b1, {16'h7fff, 1'b0, 1'b1, 1'b0});
    run_op("sat 8000-1",    16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0});

    // Eight back-to-back ops; stall output cycles 3-5 of the result stream
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.valid_out && n < 20);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.ready_in = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall ready_out", bus.ready_out, 0);
        end
        @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
      end
    join
    drain("burst");
    check("burst count", n_out - n0, 8);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.a_in = pick();
      bus.b_in = pick();
      bus.control_in = 1'($urandom_range(0, 1));
      bus.sat_in = 1'($urandom_range(0, 1));
      bus.ready_in = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain("random");

    // Reset with three ops in flight: none of them may ever appear
    n0 = n_out;
    drive_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    drive_op(16'h3333, 16'h0001, 1'b1, 1'b0);
    drive_op(16'h7fff, 16'h7fff, 1'b0, 1'b1);
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.a_in = 16'h0abc;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("post-reset valid_out", bus.valid_out, 0);
    check("post-reset ready_out", bus.ready_out, 1);
    repeat (8) begin
      @(negedge clk);
      check("flushed valid_out", bus.valid_out, 0);
    end
    check("flushed count", n_out - n0, 0);
    @(posedge clk);
    #1;
    run_op("after reset 1000-2000", 16'h1000, 16'h2000, 1'b1, 1'b0, {16'hf000, 1'b0, 1'b0, 1'b0});
    drain("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
